// File: rtl/pixel_group_scheduler_if.sv
// Request/address stream between the pixel array, the group scheduler and the readout.
// The scheduler side takes the master modport; the array/readout side takes the slave modport.
interface pixel_group_scheduler_if #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int GRP_ROWS = 4,
  parameter int GRP_COLS = 4
);
  localparam int NUM_GROUPS = (ROWS / GRP_ROWS) * (COLS / GRP_COLS);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  logic [ROWS*COLS-1:0] req_i;
  logic                 enable_i;
  logic                 ready_i;
  logic                 valid_o;
  logic [XW-1:0]        x_add_o;
  logic [YW-1:0]        y_add_o;
  logic [GW-1:0]        grp_id_o;
  logic [ROWS*COLS-1:0] gnt_o;
  logic                 active_o;
  logic                 grp_release_o;

  modport master (
    input  req_i, enable_i, ready_i,
    output valid_o, x_add_o, y_add_o, grp_id_o, gnt_o, active_o, grp_release_o
  );

  modport slave (
    output req_i, enable_i, ready_i,
    input  valid_o, x_add_o, y_add_o, grp_id_o, gnt_o, active_o, grp_release_o
  );
endinterface

// File: rtl/pixel_group_scheduler.sv
// Round-robin group scheduler: serves one pixel group at a time, emitting one registered
// x/y/group address per accepted handshake, with an optional per-visit burst limit.
//
// state | meaning
// IDLE  | no group selected; searching round-robin for the next requesting group
// SERVE | a group is selected; valid_o holds the pending pixel address
module pixel_group_scheduler #(
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int GRP_ROWS  = 4,
  parameter int GRP_COLS  = 4,
  parameter int BURST_MAX = 0
) (
  input logic                     clk_i,
  input logic                     reset_i,
  pixel_group_scheduler_if.master bus
);
  localparam int NP         = ROWS * COLS;
  localparam int GPR        = COLS / GRP_COLS;
  localparam int NUM_GROUPS = (ROWS / GRP_ROWS) * GPR;
  localparam int XW         = $clog2(COLS);
  localparam int YW         = $clog2(ROWS);
  localparam int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int CW         = $clog2(NP + 1) + 1;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t          state_q, state_n;
  logic [XW-1:0]   x_q, x_n;
  logic [YW-1:0]   y_q, y_n;
  logic [GW-1:0]   grp_q, grp_n;
  logic [GW-1:0]   ptr_q, ptr_n;
  logic [CW-1:0]   bc_q, bc_n;
  logic            rel_q, rel_n;

  logic [NUM_GROUPS-1:0] grp_any;
  logic                  rr_found;
  logic [GW-1:0]         rr_grp;
  logic [NP-1:0]         cur_onehot;
  logic [NP-1:0]         gnt;
  logic [XW+YW:0]        idle_pick, rem_pick;
  logic                  limit_hit;

  function automatic int group_of(input int r, input int c);
    return (r / GRP_ROWS) * GPR + c / GRP_COLS;
  endfunction

  // Returns {found, y, x} of the lowest-row, lowest-column set pixel of group g.
  // Scanning from the top down lets the last hit win, which is the highest-priority one.
  function automatic logic [XW+YW:0] first_pixel(input logic [NP-1:0] mask, input logic [GW-1:0] g);
    logic [XW+YW:0] res;
    res = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      for (int c = COLS - 1; c >= 0; c--) begin
        if (mask[r*COLS+c] && group_of(r, c) == int'(g))
          res = {1'b1, YW'(r), XW'(c)};
      end
    end
    return res;
  endfunction

  always_comb begin
    grp_any = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (bus.req_i[r*COLS+c]) grp_any[group_of(r, c)] = 1'b1;
  end

  // Nearest requesting group after ptr, with wrap; the pointer group itself comes last.
  always_comb begin : rr_search
    int idx;
    rr_found = 1'b0;
    rr_grp   = '0;
    idx      = 0;
    for (int i = NUM_GROUPS; i >= 1; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_GROUPS) idx = idx - NUM_GROUPS;
      if (grp_any[idx]) begin
        rr_found = 1'b1;
        rr_grp   = GW'(idx);
      end
    end
  end

  assign cur_onehot = NP'(1) << (int'(y_q) * COLS + int'(x_q));
  assign idle_pick  = first_pixel(bus.req_i, rr_grp);
  assign rem_pick   = first_pixel(bus.req_i & ~cur_onehot, grp_q);
  assign limit_hit  = (BURST_MAX != 0) && (int'(bc_q) + 1 == BURST_MAX);

  always_comb begin
    state_n = state_q;
    x_n     = x_q;
    y_n     = y_q;
    grp_n   = grp_q;
    ptr_n   = ptr_q;
    bc_n    = bc_q;
    rel_n   = 1'b0;
    gnt     = '0;
    case (state_q)
      IDLE: begin
        if (bus.enable_i && rr_found) begin
          grp_n   = rr_grp;
          x_n     = idle_pick[XW-1:0];
          y_n     = idle_pick[XW+YW-1:XW];
          state_n = SERVE;
        end
      end
      SERVE: begin
        if (bus.ready_i) begin
          gnt  = cur_onehot;
          bc_n = bc_q + CW'(1);
          if (rem_pick[XW+YW] && bus.enable_i && !limit_hit) begin
            x_n = rem_pick[XW-1:0];
            y_n = rem_pick[XW+YW-1:XW];
          end else begin
            state_n = IDLE;
            ptr_n   = grp_q;
            bc_n    = '0;
            rel_n   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (reset_i) gnt = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      grp_q   <= '0;
      ptr_q   <= GW'(NUM_GROUPS - 1);
      bc_q    <= '0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      y_q     <= y_n;
      grp_q   <= grp_n;
      ptr_q   <= ptr_n;
      bc_q    <= bc_n;
      rel_q   <= rel_n;
    end
  end

  assign bus.valid_o       = (state_q == SERVE);
  assign bus.active_o      = (state_q == SERVE);
  assign bus.x_add_o       = x_q;
  assign bus.y_add_o       = y_q;
  assign bus.grp_id_o      = grp_q;
  assign bus.gnt_o         = gnt;
  assign bus.grp_release_o = rel_q;
endmodule

// File: doc/pixel_group_scheduler.md
# pixel_group_scheduler

Parametrised successor to the fixed-level pixel grouping stage. It splits a ROWS x COLS event-pixel request array into GRP_ROWS x GRP_COLS groups and selects one group at a time, round-robin across groups. It then serves that group's pending pixels one per accepted handshake and emits registered x/y/group addresses on a valid/ready stream. It adds three behaviours the previous stage lacked:
- Output back-pressure.
- A configurable burst limit per group.
- Registered group-release signalling.

It sits between the pixel array and the address encoder/readout.

## Interface
- ROWS, 16, pixel array rows; must be a multiple of GRP_ROWS
- COLS, 16, pixel array columns; must be a multiple of GRP_COLS
- GRP_ROWS, 4, rows per group
- GRP_COLS, 4, columns per group
- BURST_MAX, 0, maximum events per group visit; 0 = drain the group until empty
- Derived values:
  - NUM_GROUPS = (ROWS/GRP_ROWS)*(COLS/GRP_COLS)
  - XW = $clog2(COLS), YW = $clog2(ROWS), GW = max(1,$clog2(NUM_GROUPS))

- clk_i  in  1  single clock, rising edge
- reset_i  in  1  synchronous, active-high reset
- req_i  in  ROWS*COLS  pixel requests; bit index r*COLS+c
- enable_i  in  1  permits starting and continuing group service
- ready_i  in  1  downstream ready
- valid_o  out  1  event address valid
- x_add_o  out  XW  column of the pending event
- y_add_o  out  YW  row of the pending event
- grp_id_o  out  GW  group of the pending or active event
- gnt_o  out  ROWS*COLS  one-hot grant to the accepted pixel; combinational, asserted only in the accept cycle
- active_o  out  1  a group is currently being served
- grp_release_o  out  1  one-cycle pulse after a group visit ends

## Operation
- Group numbering: g = (r/GRP_ROWS)*(COLS/GRP_COLS) + c/GRP_COLS.
- Priority inside a group is fixed: lowest row first, then lowest column.
- State machine has two states, IDLE and SERVE.
- IDLE:
  - If enable_i=1 and any req_i bit is set, pick the first group with a request, searching round-robin from ptr+1 with wrap.
  - Load grp_id, x and y of that group's highest-priority pixel. Set valid=1. Go to SERVE.
  - Otherwise stay in IDLE with valid=0.
- SERVE, accept cycle (valid_o & ready_i):
  - gnt_o = one-hot(y*COLS+x).
  - burst_cnt increments.
  - rem = the group's req_i bits AND NOT gnt_o.
  - Continue condition: rem != 0 AND enable_i AND NOT (BURST_MAX != 0 AND burst_cnt+1 == BURST_MAX).
  - If the continue condition holds: load the highest-priority pixel of rem; valid stays 1.
  - Otherwise: valid <= 0, state <= IDLE, ptr <= grp_id, burst_cnt <= 0, grp_release_o <= 1 on the next cycle.
- SERVE with valid_o & !ready_i: x, y and grp_id hold stable; gnt_o=0.
- A latched event is delivered even if its req_i bit drops before grant. Pixels hold req until granted.
- enable_i=0 during SERVE: the pending event still completes, then the group releases. No new group starts while enable_i=0.
- The round-robin pointer advances only on release. A group is reselected immediately only if it is the sole requester.
- active_o = (state == SERVE).

## Timing
- Reset values (any cycle, including mid-handshake):
  - state=IDLE, valid_o=0, x_add_o=0, y_add_o=0, grp_id_o=0, burst_cnt=0, grp_release_o=0, active_o=0.
  - ptr = NUM_GROUPS-1, so group 0 is searched first.
  - gnt_o is forced to 0 while reset_i=1.
- Latency: request seen in IDLE at cycle t gives valid_o=1 at t+1.
- Throughput inside a group is 1 event per cycle with ready_i held high.
- Group switch: last accept at cycle t; grp_release_o=1 and state=IDLE at t+1; next group's valid_o at t+2. This is one bubble cycle.
- gnt_o is never asserted when valid_o=0.

## Test plan
- Drain within one group: ROWS=COLS=16, group 4x4, BURST_MAX=0, pixels (0,0),(1,2),(3,3) set, ready high.
  - Required: events (x,y) = (0,0),(2,1),(3,3) on consecutive cycles, each with the matching gnt_o bit.
  - Then grp_release_o pulses once; active_o falls.
- Round-robin across groups: single pixels in groups 0, 5 and 15, all held.
  - Required: service order 0,5,15, then 0 again once it re-requests.
  - Exactly one bubble cycle between groups.
- Burst limit: BURST_MAX=2, group 0 has 4 requests, group 1 has 1 request.
  - Required order: g0 (0,0), g0 (1,0), g1 event, g0 (2,0), g0 (3,0).
- Back-pressure: ready_i low for 5 cycles with valid_o high.
  - Required: x, y and grp_id stable; gnt_o=0 throughout; grant in the cycle ready rises.
- Enable and reset:
  - enable_i dropped mid-group: pending event completes, then release; no new valid_o while enable_i=0.
  - reset_i asserted mid-burst: next cycle all outputs are at reset values, and gnt_o=0 during the reset cycle.
